prog_period_tick_gen: RTL

//   Parametrised, glitch-free test-signal source for the low-frequency counter benches.

---
 rtl/prog_period_tick_gen.sv | 100 ++++++++++
 1 files changed

// File: rtl/prog_period_tick_gen.sv
// Programmable-period tick and square-wave source.
// A new period is adopted only at a wrap or restart, never mid-period.
module prog_period_tick_gen #(
  parameter int unsigned W          = 27,
  parameter int unsigned PER0       = 11_000,
  parameter int unsigned PER1       = 20_000,
  parameter int unsigned PER2       = 100_000,
  parameter int unsigned PER3       = 300_000,
  parameter int unsigned PER4       = 6_000_000,
  parameter int unsigned PER5       = 17_000_000,
  parameter int unsigned PER6       = 76_000_000,
  parameter int unsigned PER7       = 100_000_000,
  parameter int unsigned CUSTOM_DEF = 1_000,
  parameter int unsigned TW         = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          restart,
  input  logic [2:0]    sel,
  input  logic          use_custom,
  input  logic          load,
  input  logic [W-1:0]  load_val,
  output logic          tick,
  output logic          sq,
  output logic [W-1:0]  period,
  output logic [TW-1:0] tick_cnt
);

  function automatic logic [W-1:0] clamp(input logic [W-1:0] x);
    return (x < W'(2)) ? W'(2) : x;
  endfunction

  localparam logic [W-1:0] P0_RST = (W'(PER0) < W'(2)) ? W'(2) : W'(PER0);

  logic [W-1:0]  cnt_q, cnt_d;
  logic [W-1:0]  p_act_q, p_act_d;
  logic [W-1:0]  custom_q, custom_d;
  logic [TW-1:0] tc_q, tc_d;
  logic [W-1:0]  preset;
  logic [W-1:0]  p_sel;
  logic          wrap;

  always_comb begin
    preset = W'(PER0);
    unique case (sel)
      3'd0: preset = W'(PER0);
      3'd1: preset = W'(PER1);
      3'd2: preset = W'(PER2);
      3'd3: preset = W'(PER3);
      3'd4: preset = W'(PER4);
      3'd5: preset = W'(PER5);
      3'd6: preset = W'(PER6);
      3'd7: preset = W'(PER7);
    endcase
  end

  // custom_q (not custom_d) so a load coinciding with restart sees the old value
  assign p_sel = use_custom ? custom_q : preset;
  assign wrap  = (cnt_q == p_act_q - W'(1));

  always_comb begin
    cnt_d    = cnt_q;
    p_act_d  = p_act_q;
    tc_d     = tc_q;
    custom_d = load ? load_val : custom_q;
    if (restart) begin
      cnt_d   = '0;
      p_act_d = clamp(p_sel);
    end else if (en) begin
      if (wrap) begin
        cnt_d   = '0;
        p_act_d = clamp(p_sel);
        tc_d    = tc_q + TW'(1);
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      p_act_q  <= P0_RST;
      custom_q <= W'(CUSTOM_DEF);
      tc_q     <= '0;
    end else begin
      cnt_q    <= cnt_d;
      p_act_q  <= p_act_d;
      custom_q <= custom_d;
      tc_q     <= tc_d;
    end
  end

  assign tick     = en & wrap;
  assign sq       = (cnt_q < (p_act_q >> 1));
  assign period   = p_act_q;
  assign tick_cnt = tc_q;

endmodule
